// File: rtl/bomb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bomb_game_sequencer
// Purpose  : Game-phase controller for the bomb-defusal game.
//            Home -> Flow puzzle -> Defuse (wire cut) -> Win / Lose.
//            It owns the countdown, strikes, penalties and the win/lose
//            verdict. It also drives the screen muxes and the minigame resets.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_game_sequencer #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int TIME_SEC    = 60,
  parameter int PENALTY_SEC = 10,
  parameter int MAX_STRIKES = 3
) (
  input  logic       basys_clock,
  input  logic       reset_n,
  input  logic       arm,
  input  logic       is_connected,
  input  logic [2:0] wire_to_cut,
  input  logic       cut_valid,
  input  logic [2:0] cut_id,
  output logic [2:0] phase,
  output logic [6:0] seconds,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] strikes,
  output logic       game_rst,
  output logic       tick,
  output logic       win,
  output logic       lose
);

  localparam int                   PRESC_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST   = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]   PRESC_ONE    = PRESC_W'(1);
  localparam logic [6:0]           SEC_INIT     = 7'(TIME_SEC);
  localparam logic [7:0]           PENALTY      = 8'(PENALTY_SEC);
  localparam logic [1:0]           STRIKE_LIMIT = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {
    S_HOME   = 3'd0,
    S_FLOW   = 3'd1,
    S_DEFUSE = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         seconds_q, seconds_d;
  logic [1:0]         strikes_q, strikes_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               game_rst_q, win_q, lose_q;

  logic               w_terminal;
  logic [7:0]         w_loss;
  logic [7:0]         w_sec_ext;
  logic [6:0]         w_sec_after;
  logic [1:0]         w_strikes_inc;
  logic               w_strike_out;

  // The prescaler is at its last count, so this edge is a countdown second.
  assign w_terminal    = (presc_q == PRESC_LAST);
  assign w_sec_ext     = {1'b0, seconds_q};
  assign w_strikes_inc = (strikes_q == STRIKE_LIMIT) ? strikes_q : strikes_q + 2'd1;

  // Next-state logic. A correct cut preempts the countdown for that edge.
  // A wrong cut stacks its penalty on a coincident tick.
  always_comb begin
    state_d      = state_q;
    seconds_d    = seconds_q;
    strikes_d    = strikes_q;
    presc_d      = presc_q;
    tick_d       = 1'b0;
    w_loss       = 8'd0;
    w_sec_after  = seconds_q;
    w_strike_out = 1'b0;

    if (state_q != S_HOME && !arm) begin
      // Abort: return home with a fresh bomb.
      state_d   = S_HOME;
      seconds_d = SEC_INIT;
      strikes_d = 2'd0;
      presc_d   = '0;
    end else begin
      case (state_q)
        S_HOME: begin
          seconds_d = SEC_INIT;
          strikes_d = 2'd0;
          presc_d   = '0;
          if (arm) state_d = S_FLOW;
        end
        S_FLOW, S_DEFUSE: begin
          if (state_q == S_DEFUSE && cut_valid && cut_id == wire_to_cut) begin
            state_d = S_WIN;
          end else begin
            presc_d = w_terminal ? '0 : presc_q + PRESC_ONE;
            tick_d  = w_terminal;
            w_loss  = {7'd0, w_terminal};
            if (state_q == S_DEFUSE && cut_valid) begin
              strikes_d = w_strikes_inc;
              if (w_strikes_inc == STRIKE_LIMIT) w_strike_out = 1'b1;
              else                               w_loss = w_loss + PENALTY;
            end
            w_sec_after = (w_sec_ext <= w_loss) ? 7'd0 : 7'(w_sec_ext - w_loss);
            seconds_d   = w_sec_after;
            if (w_strike_out || w_sec_after == 7'd0) state_d = S_LOSE;
            else if (state_q == S_FLOW && is_connected) state_d = S_DEFUSE;
          end
        end
        S_WIN, S_LOSE: begin
          // Terminal phases keep their state frozen until an abort or reset.
        end
        default: begin
          state_d = S_HOME;
        end
      endcase
    end
  end

  // State and output registers. Flags are decoded from the next state so they line up with phase.
  always_ff @(posedge basys_clock) begin
    if (!reset_n) begin
      state_q    <= S_HOME;
      seconds_q  <= SEC_INIT;
      strikes_q  <= 2'd0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      game_rst_q <= 1'b1;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seconds_q  <= seconds_d;
      strikes_q  <= strikes_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      game_rst_q <= (state_d == S_HOME);
      win_q      <= (state_d == S_WIN);
      lose_q     <= (state_d == S_LOSE);
    end
  end

  assign phase    = state_q;
  assign seconds  = seconds_q;
  assign strikes  = strikes_q;
  assign tick     = tick_q;
  assign game_rst = game_rst_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign sec_tens = 4'(seconds_q / 7'd10);
  assign sec_ones = 4'(seconds_q % 7'd10);

endmodule
`default_nettype wire
